alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter ALU_WAIT, default 1, giving the number of cycles to hold operands before sampling the ALU result; the legal range is 1..15.
REQ-002 CLK  in  1  single clock; all state updates on the rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 CMD_VALID  in  1  command offered.
REQ-005 CMD_READY  out  1  command accepted when high together with CMD_VALID.
REQ-006 CMD_OP  in  3  ALU opcode, passed through unchanged.
REQ-007 CMD_RA, CMD_RB  in  2 each  source register indices.
REQ-008 CMD_RD  in  2  destination register index.
REQ-009 CMD_WE  in  1  write-back enable; 0 means compare/test only.
REQ-010 LD_VALID  in  1, LD_ADDR  in  2, LD_DATA  in  8  direct register-file load.
REQ-011 ALU_A, ALU_B  out  8, ALU_OP  out  3  operands and opcode driven to the ALU.
REQ-012 ALU_Y  in  8, ALU_FLAGS  in  4 {C,V,N,Z}  ALU result and flags.
REQ-013 RES_VALID  out  1, RES_READY  in  1, RES_Y  out  8, RES_FLAGS  out  4  result handshake.
REQ-014 RD_ADDR  in  2, RD_DATA  out  8  combinational register read port, used for the display.
REQ-015 BUSY  out  1  high in any state other than IDLE.

Function
REQ-016 The block SHALL hold a 4 x 8-bit register file R0..R3.
REQ-017 The FSM SHALL have states IDLE, WAIT, CAPTURE and RESP.
REQ-018 CMD_READY SHALL be 1 only in IDLE.
- Accept occurs at an edge where CMD_VALID=1 and CMD_READY=1.
- On accept: R[CMD_RA] and R[CMD_RB] are snapshotted into ALU_A/ALU_B, CMD_OP into ALU_OP, CMD_RD and CMD_WE are latched, a counter is loaded with ALU_WAIT, and the FSM goes to WAIT.
REQ-019 ALU_A, ALU_B and ALU_OP SHALL be registered and SHALL hold their values from the accept edge until the next accept edge.
- Loads issued after accept SHALL NOT alter in-flight operands.
REQ-020 In WAIT, the counter SHALL decrement each cycle; when it reaches 1, the next state SHALL be CAPTURE.
- With ALU_WAIT=N, the operands are stable for exactly N cycles before capture.
REQ-021 CAPTURE SHALL last one cycle and perform the following at its edge:
- sample ALU_Y into RES_Y and ALU_FLAGS into RES_FLAGS;
- if the latched WE=1, write ALU_Y to R[latched RD];
- go to RESP.
REQ-022 In RESP, RES_VALID SHALL be 1.
- RES_Y and RES_FLAGS SHALL hold stable until an edge with RES_READY=1; the block then goes to IDLE.
- A RES_READY held high gives a one-cycle RESP.
REQ-023 Accept-to-RES_VALID latency SHALL be ALU_WAIT+1 cycles.
- Minimum command period with RES_READY tied high is ALU_WAIT+3 cycles.
REQ-024 An LD_VALID write SHALL take effect at the next edge in any state.
- If it coincides with a CAPTURE write-back to the same address, the write-back wins.
- Writes to different addresses both complete.
REQ-025 An LD_VALID write in the same cycle as an accept SHALL NOT be visible to that command's snapshot; the snapshot uses pre-edge contents.
REQ-026 RD_DATA SHALL equal R[RD_ADDR] combinationally, reflecting writes from the following cycle onward.
REQ-027 CMD_VALID outside IDLE SHALL be ignored, and no command is lost or queued internally.

Reset
REQ-028 While RESET=1 at an edge, the block SHALL go to IDLE, clear R0..R3, ALU_A, ALU_B, ALU_OP, RES_Y, RES_FLAGS and the counter to 0, and force RES_VALID=0 and BUSY=0.
REQ-029 CMD_READY SHALL be 0 during any cycle in which RESET=1.
REQ-030 A reset in WAIT, CAPTURE or RESP SHALL abort the operation with no register write-back and no RES_VALID pulse.
REQ-031 Reset SHALL take priority over LD_VALID and over CMD accept.

Verification
REQ-032 The bench SHALL use a behavioral ALU model returning Y=A+B and setting the flags for OP=000, and SHALL cover the following directed scenarios.
- Basic op: load R0=0x12, R1=0x34; command OP=000, RA=0, RB=1, RD=2, WE=1; ALU_WAIT=1 -> RES_VALID 2 cycles after accept, RES_Y=0x46, RES_FLAGS=0000, R2=0x46.
- Carry/zero: R0=0xFF, R1=0x01, WE=0 -> RES_Y=0x00, C=1, Z=1, R0..R3 unchanged.
- Backpressure: hold RES_READY=0 for 5 cycles -> RES_VALID, RES_Y and RES_FLAGS stable; CMD_READY=0; a second CMD_VALID is ignored; IDLE one cycle after RES_READY=1.
- Load collision: LD to R2 = 0xAA in the CAPTURE cycle of a WE=1 write to R2 -> R2 holds the ALU result; the same load to R3 -> R3=0xAA.
- Snapshot: an LD to R0 = 0x99 on the accept edge -> the operand uses the old R0; RD_DATA(0)=0x99 afterwards.
- Reset mid-op: assert RESET in WAIT with ALU_WAIT=4 -> the next cycle shows BUSY=0, RES_VALID=0, all registers 0 and CMD_READY=1 once RESET drops.

Source files
------------

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation: snapshot operands from a 4x8 register file, hold them
// for ALU_WAIT cycles, capture the result with optional write-back, then hand it off.
module alu_sequencer #(
    parameter int ALU_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [1:0] cmd_ra,
    input  logic [1:0] cmd_rb,
    input  logic [1:0] cmd_rd,
    input  logic       cmd_we,
    input  logic       ld_valid,
    input  logic [1:0] ld_addr,
    input  logic [7:0] ld_data,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_y,
    input  logic [3:0] alu_flags,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_y,
    output logic [3:0] res_flags,
    input  logic [1:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, RESP} state_t;

    typedef struct packed {
        logic [1:0] rd;
        logic       we;
    } wb_t;

    state_t          state;
    logic [3:0]      cnt;
    wb_t             wb;
    logic [3:0][7:0] rf;

    // Masked by reset so a command offered during reset is never seen as accepted.
    assign cmd_ready = (state == IDLE) && !reset;
    assign busy      = (state != IDLE);
    assign res_valid = (state == RESP);
    assign rd_data   = rf[rd_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            wb        <= '0;
            rf        <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            res_y     <= '0;
            res_flags <= '0;
        end else begin
            if (ld_valid)
                rf[ld_addr] <= ld_data;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a    <= rf[cmd_ra];
                        alu_b    <= rf[cmd_rb];
                        alu_op   <= cmd_op;
                        wb.rd    <= cmd_rd;
                        wb.we    <= cmd_we;
                        cnt      <= ALU_WAIT[3:0];
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1)
                        state <= CAPTURE;
                end
                CAPTURE: begin
                    res_y     <= alu_y;
                    res_flags <= alu_flags;
                    // Placed after the load so write-back wins on an address collision.
                    if (wb.we)
                        rf[wb.rd] <= alu_y;
                    state <= RESP;
                end
                RESP: begin
                    if (res_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
